pipelined_adder: RTL and testbench

//   Parametrised N-bit adder (a + b + carry_in) with the carry chain split across

---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_slice.sv | 23 ++
 rtl/pipelined_adder.sv | 145 ++++++++++++++
 tb/tb_pipelined_adder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and the
// parameter legality check used at elaboration time.
package adder_pkg;

    // Bits resolved by each pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // The carry chain can only be split evenly when WIDTH is a multiple of STAGES.
    function automatic bit chunk_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit adder slice: s/cout = a + b + cin.
// msb_cin is the carry entering the slice's top bit, needed for signed
// overflow detection on the most significant slice.
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             msb_cin
);

    // Ripple add of one chunk, one bit wider to expose the carry out.
    always_comb begin
        {cout, s} = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);
    end

    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out of the sum.
    assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder (a + b + carry_in) with the carry chain split
// over STAGES register stages and valid/ready flow control that squeezes
// out bubbles. Optional signed overflow output: define OVERFLOW_DETECT_EN.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef OVERFLOW_DETECT_EN
    ,
    output logic             overflow
`endif
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!chunk_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    // Per-stage state: valid bit, carry out of the stage's chunk, the sum
    // bits resolved so far, and the operands whose upper chunks are still pending.
    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;

    // Stage inputs (from the ports for stage 0, from the previous stage otherwise).
    logic [STAGES-1:0]            vin;
    logic [STAGES-1:0]            cin_s;
    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, sum_in;

    // Slice adder results.
    logic [STAGES-1:0][CHUNK-1:0] s_slice;
    logic [STAGES-1:0]            cout_slice;
    logic [STAGES-1:0]            msb_slice;

    logic [STAGES-1:0]            adv;

    // Advance chain: a stage may capture when it is empty or the stage
    // downstream of it is moving; this is what collapses bubbles under stall.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !valid_q[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !valid_q[k] | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign vin[gi]    = in_valid;
            assign cin_s[gi]  = carry_in;
            assign a_in[gi]   = a;
            assign b_in[gi]   = b;
            assign sum_in[gi] = '0;
        end else begin : g_next
            assign vin[gi]    = valid_q[gi-1];
            assign cin_s[gi]  = carry_q[gi-1];
            assign a_in[gi]   = a_q[gi-1];
            assign b_in[gi]   = b_q[gi-1];
            assign sum_in[gi] = sum_q[gi-1];
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a       (a_in[gi][CHUNK*gi +: CHUNK]),
            .b       (b_in[gi][CHUNK*gi +: CHUNK]),
            .cin     (cin_s[gi]),
            .s       (s_slice[gi]),
            .cout    (cout_slice[gi]),
            .msb_cin (msb_slice[gi])
        );

        // Bits above the resolved region are always zero, so OR-ing the new
        // chunk in place is enough to merge it with the lower sum bits.
        assign valid_d[gi] = adv[gi] ? vin[gi] : valid_q[gi];
        assign carry_d[gi] = adv[gi] ? cout_slice[gi] : carry_q[gi];
        assign a_d[gi]     = adv[gi] ? a_in[gi] : a_q[gi];
        assign b_d[gi]     = adv[gi] ? b_in[gi] : b_q[gi];
        assign sum_d[gi]   = adv[gi] ? (sum_in[gi] | (WIDTH'(s_slice[gi]) << (CHUNK*gi)))
                                     : sum_q[gi];
    end

    // Pipeline registers; data is cleared too so nothing undefined reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign carry_out = carry_q[STAGES-1];

`ifdef OVERFLOW_DETECT_EN
    logic ovf_q, ovf_d;

    // Signed overflow = carry into the MSB differs from carry out of it.
    assign ovf_d = adv[STAGES-1] ? (msb_slice[STAGES-1] ^ cout_slice[STAGES-1]) : ovf_q;

    // Overflow flag travels with the last stage, same valid and latency as sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    // Operand bits below each stage's chunk and the final-stage operands are
    // never consumed; they are kept full width for uniform stage structure.
    logic unused_bits;
    assign unused_bits = ^{a_q, b_q, msb_slice};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
// Define OVERFLOW_DETECT_EN to also check the overflow port.
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
`ifdef OVERFLOW_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             ov_obs;
`ifdef OVERFLOW_DETECT_EN
    logic             overflow;
    assign ov_obs = overflow;
`else
    assign ov_obs = 1'b0;
`endif

    logic [17:0] obs_v;
    assign obs_v = {ov_obs, carry_out, sum};

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef OVERFLOW_DETECT_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t        tbl [14];
    logic [17:0] exp_q [$];
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          acc_cnt = 0;
    int          out_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        int unsigned u;
        int          sx, sy, s;
        logic        ov;
        u  = int'(x) + int'(y) + int'(c);
        sx = $signed(x);
        sy = $signed(y);
        s  = sx + sy + int'(c);
        ov = (s > 32767) || (s < -32768);
        if (!OVF_EN) ov = 1'b0;
        return {ov, u[16], u[15:0]};
    endfunction

    // Output scoreboard: every valid output must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk(out_ready ? "stream result" : "stalled result", 32'(obs_v), 32'(exp_q[0]));
                if (out_ready) begin
                    $display("txn %0d: sum=0x%04h carry_out=%0b overflow=%0b", out_cnt, sum, carry_out, ov_obs);
                    out_cnt++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Present one operand set; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        logic acc;
        int   guard;
        guard    = 0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        carry_in = cv;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(model(av, bv, cv));
                acc_cnt++;
                break;
            end
            guard++;
            if (guard > 200) begin
                chk("accept timeout", 32'd0, 32'd1);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    // Single transaction into an empty pipe: latency, value and one-cycle pulse.
    task automatic send_timed(input vec_t v, input string name);
        int n;
        send(v.a, v.b, v.cin);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        chk({name, " latency"}, n, 32'd4);
        chk({name, " sum"}, 32'(sum), 32'(v.s));
        chk({name, " carry_out"}, 32'(carry_out), 32'(v.co));
        if (OVF_EN) chk({name, " overflow"}, 32'(ov_obs), 32'(v.ov));
        @(posedge clk);
        @(negedge clk);
        chk({name, " single pulse"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain remaining", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int   start_acc;
        int   seen;
        logic acc;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            tbl[6+k].a   = {15'd0, k[2]};
            tbl[6+k].b   = {15'd0, k[1]};
            tbl[6+k].cin = k[0];
            tbl[6+k].s   = 16'(int'(k[2]) + int'(k[1]) + int'(k[0]));
            tbl[6+k].co  = 1'b0;
            tbl[6+k].ov  = 1'b0;
        end

        // Reset state.
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset carry_out", 32'(carry_out), 32'd0);
        if (OVF_EN) chk("reset overflow", 32'(ov_obs), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, one at a time through an empty pipe.
        for (int i = 0; i < 14; i++) begin
            send_timed(tbl[i], $sformatf("vec%0d", i));
        end

        // Stall: exactly STAGES ops held, then release and drain in order.
        out_ready = 1'b0;
        start_acc = acc_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(16'(16'h1000 * (i + 1) + i), 16'(16'h0F0F + i), 1'(i));
                end
            end
            begin
                repeat (10) @(negedge clk);
                chk("stall accepted count", acc_cnt - start_acc, 32'd4);
                chk("stall in_ready", 32'(in_ready), 32'd0);
                chk("stall out_valid held", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall total accepted", acc_cnt - start_acc, 32'd6);

        // Reset with two operations in flight.
        send(16'hAAAA, 16'h5555, 1'b0);
        send(16'h0101, 16'h0202, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("out_valid after mid-flight reset", seen, 32'd0);
        @(posedge clk);
        #1;
        send_timed(tbl[5], "post-reset op");

        // Random stream with random back-pressure against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
            carry_in  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(model(a, b, carry_in));
                acc_cnt++;
            end
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("outputs equal inputs", out_cnt, 32'(acc_cnt - 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
